wb_master_adapter: RTL

- Wishbone classic single-transfer master (initiator) that bridges the RV32I load/store unit onto the NoC Wishbone fabric.
- Drives slaves such as the LED matrix and RAM wrappers.
- Converts a valid/ready CPU request into one cyc/stb cycle, generates byte lanes and write data, and returns aligned, sign/zero-extended read data with an error flag.

---
 rtl/wb_master_pkg.sv | 19 +
 rtl/wb_master_lane_align.sv | 59 +++++
 rtl/wb_master_adapter.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/wb_master_pkg.sv
// Shared size codes, FSM encoding and timeout counter sizing
// for the Wishbone classic single-transfer master.
package wb_master_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } state_e;

    function automatic int tmo_width(input int cycles);
        return $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/wb_master_lane_align.sv
// Byte-lane select / write replication, alignment check and
// load extraction with sign or zero extension.
module wb_master_lane_align
    import wb_master_pkg::*;
(
    input  logic [1:0]  tx_off_i,
    input  logic [1:0]  tx_size_i,
    input  logic [31:0] tx_wdata_i,
    output logic [3:0]  tx_sel_o,
    output logic [31:0] tx_dat_o,
    output logic        tx_illegal_o,
    input  logic [1:0]  rx_off_i,
    input  logic [1:0]  rx_size_i,
    input  logic        rx_unsigned_i,
    input  logic [31:0] rx_dat_i,
    output logic [31:0] rx_rdata_o
);

    logic [31:0] rx_shift;
    logic        rx_sign;

    always_comb begin
        tx_sel_o     = 4'b1111;
        tx_dat_o     = tx_wdata_i;
        tx_illegal_o = 1'b0;
        case (tx_size_i)
            SIZE_BYTE: begin
                tx_sel_o = 4'b0001 << tx_off_i;
                tx_dat_o = {4{tx_wdata_i[7:0]}};
            end
            SIZE_HALF: begin
                tx_sel_o     = 4'b0011 << tx_off_i;
                tx_dat_o     = {2{tx_wdata_i[15:0]}};
                tx_illegal_o = tx_off_i[0];
            end
            SIZE_WORD: tx_illegal_o = (tx_off_i != 2'b00);
            default:   tx_illegal_o = 1'b1;
        endcase
    end

    assign rx_shift = rx_dat_i >> {rx_off_i, 3'b000};

    always_comb begin
        rx_sign    = 1'b0;
        rx_rdata_o = rx_shift;
        case (rx_size_i)
            SIZE_BYTE: begin
                rx_sign    = ~rx_unsigned_i & rx_shift[7];
                rx_rdata_o = {{24{rx_sign}}, rx_shift[7:0]};
            end
            SIZE_HALF: begin
                rx_sign    = ~rx_unsigned_i & rx_shift[15];
                rx_rdata_o = {{16{rx_sign}}, rx_shift[15:0]};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/wb_master_adapter.sv
// Wishbone classic master bridging the load/store unit to the fabric.
// Define WB_MASTER_TIMEOUT_EN to force-terminate stalled bus cycles.
module wb_master_adapter
    import wb_master_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    input  logic [1:0]  req_size_i,
    input  logic        req_unsigned_i,
    output logic        rsp_valid_o,
    output logic [31:0] rsp_rdata_o,
    output logic        rsp_err_o,
    output logic [31:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    output logic [3:0]  wb_sel_o,
    output logic        wb_we_o,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack_i,
    input  logic        wb_err_i
);

    if (TIMEOUT_CYCLES < 1) begin : g_bad_tmo
        $error("TIMEOUT_CYCLES must be >= 1");
    end

    state_e      state_q, state_d;
    logic        cyc_q, cyc_d;
    logic        we_q, we_d;
    logic [31:0] adr_q, adr_d;
    logic [31:0] dat_q, dat_d;
    logic [3:0]  sel_q, sel_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic        rsp_err_q, rsp_err_d;
    logic [31:0] rdata_q, rdata_d;
    logic [1:0]  off_q, off_d;
    logic [1:0]  size_q, size_d;
    logic        uns_q, uns_d;

    logic [3:0]  tx_sel;
    logic [31:0] tx_dat;
    logic        tx_illegal;
    logic [31:0] rx_rdata;

`ifdef WB_MASTER_TIMEOUT_EN
    localparam int TMO_W = tmo_width(TIMEOUT_CYCLES);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
    logic [TMO_W-1:0] tmo_q, tmo_d;
`endif

    wb_master_lane_align u_lane (
        .tx_off_i      (req_addr_i[1:0]),
        .tx_size_i     (req_size_i),
        .tx_wdata_i    (req_wdata_i),
        .tx_sel_o      (tx_sel),
        .tx_dat_o      (tx_dat),
        .tx_illegal_o  (tx_illegal),
        .rx_off_i      (off_q),
        .rx_size_i     (size_q),
        .rx_unsigned_i (uns_q),
        .rx_dat_i      (wb_dat_i),
        .rx_rdata_o    (rx_rdata)
    );

    always_comb begin
        state_d     = state_q;
        cyc_d       = cyc_q;
        we_d        = we_q;
        adr_d       = adr_q;
        dat_d       = dat_q;
        sel_d       = sel_q;
        off_d       = off_q;
        size_d      = size_q;
        uns_d       = uns_q;
        rsp_valid_d = 1'b0;
        rsp_err_d   = rsp_err_q;
        rdata_d     = rdata_q;
`ifdef WB_MASTER_TIMEOUT_EN
        tmo_d       = tmo_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (req_valid_i) begin
                    rsp_err_d = 1'b0;
                    rdata_d   = '0;
                    if (tx_illegal) begin
                        state_d     = RESP;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                    end else begin
                        state_d = BUS;
                        cyc_d   = 1'b1;
                        we_d    = req_we_i;
                        adr_d   = {req_addr_i[31:2], 2'b00};
                        dat_d   = tx_dat;
                        sel_d   = tx_sel;
                        off_d   = req_addr_i[1:0];
                        size_d  = req_size_i;
                        uns_d   = req_unsigned_i;
`ifdef WB_MASTER_TIMEOUT_EN
                        tmo_d   = '0;
`endif
                    end
                end
            end
            BUS: begin
                // err outranks ack; a failed load returns zero data
                if (wb_err_i | wb_ack_i) begin
                    state_d     = RESP;
                    cyc_d       = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = wb_err_i;
                    rdata_d     = (wb_err_i | we_q) ? '0 : rx_rdata;
                end
`ifdef WB_MASTER_TIMEOUT_EN
                else if (tmo_q == TMO_LAST) begin
                    state_d     = RESP;
                    cyc_d       = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    rdata_d     = '0;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
`endif
            end
            RESP: begin
                state_d   = IDLE;
                rsp_err_d = 1'b0;
                rdata_d   = '0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            cyc_q       <= 1'b0;
            we_q        <= 1'b0;
            adr_q       <= '0;
            dat_q       <= '0;
            sel_q       <= '0;
            off_q       <= '0;
            size_q      <= '0;
            uns_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rdata_q     <= '0;
`ifdef WB_MASTER_TIMEOUT_EN
            tmo_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            cyc_q       <= cyc_d;
            we_q        <= we_d;
            adr_q       <= adr_d;
            dat_q       <= dat_d;
            sel_q       <= sel_d;
            off_q       <= off_d;
            size_q      <= size_d;
            uns_q       <= uns_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rdata_q     <= rdata_d;
`ifdef WB_MASTER_TIMEOUT_EN
            tmo_q       <= tmo_d;
`endif
        end
    end

    assign req_ready_o = (state_q == IDLE);
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_err_o   = rsp_err_q;
    assign rsp_rdata_o = rdata_q;
    assign wb_adr_o    = adr_q;
    assign wb_dat_o    = dat_q;
    assign wb_sel_o    = sel_q;
    assign wb_we_o     = we_q;
    assign wb_cyc_o    = cyc_q;
    assign wb_stb_o    = cyc_q;

endmodule
